// File: rtl/interrupt_controller.sv
// Prioritised, non-nesting interrupt controller driving the PC acknowledge/restore path.
// Rising edges on irq become pending; the lowest-index enabled line is granted at an instruction boundary.
module interrupt_controller #(
  parameter int NUM_IRQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic                int_enable,
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_in,
  input  logic                instr_boundary,
  input  logic                reti,
  output logic                inta,
  output logic                pc_restore,
  output logic [ID_WIDTH-1:0] irq_id,
  output logic                in_service,
  output logic [NUM_IRQ-1:0]  pending,
  output logic [NUM_IRQ-1:0]  mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    SERVICE = 2'd2,
    RETURN  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [NUM_IRQ-1:0]   irq_q_r;
  logic [NUM_IRQ-1:0]   pending_r;
  logic [NUM_IRQ-1:0]   mask_r;
  logic [ID_WIDTH-1:0]  irq_id_r;
  logic                 inta_r;
  logic                 pc_restore_r;
  logic                 in_service_r;

  logic [NUM_IRQ-1:0]   rise_s;
  logic [NUM_IRQ-1:0]   req_s;
  logic [NUM_IRQ-1:0]   grant_clr_s;
  logic [NUM_IRQ-1:0]   pending_s;
  logic [ID_WIDTH-1:0]  win_id_s;
  logic                 grant_s;

  // Scanning downward makes bit 0 the last writer, so the lowest index wins.
  function automatic logic [ID_WIDTH-1:0] lowest_index(input logic [NUM_IRQ-1:0] vec);
    logic [ID_WIDTH-1:0] idx;
    idx = {ID_WIDTH{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ID_WIDTH'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Edge detection and gated request vector.
  always_comb begin
    rise_s = irq & ~irq_q_r;
    if (int_enable) begin
      req_s = pending_r & mask_r;
    end else begin
      req_s = {NUM_IRQ{1'b0}};
    end
    win_id_s = lowest_index(req_s);
  end

  // Next-state logic for the acknowledge/return sequence.
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (instr_boundary && (req_s != {NUM_IRQ{1'b0}})) begin
          grant_s = 1'b1;
          state_s = ACK;
        end else begin
          state_s = IDLE;
        end
      end
      ACK: begin
        state_s = SERVICE;
      end
      SERVICE: begin
        if (reti) begin
          state_s = RETURN;
        end else begin
          state_s = SERVICE;
        end
      end
      RETURN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Pending update: a fresh rise on the granted line survives its own clear.
  always_comb begin
    grant_clr_s = {NUM_IRQ{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (grant_s && (win_id_s == ID_WIDTH'(i))) begin
        grant_clr_s[i] = 1'b1;
      end else begin
        grant_clr_s[i] = 1'b0;
      end
    end
    pending_s = (pending_r & ~grant_clr_s) | rise_s;
  end

  // State, request tracking and mask registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      irq_q_r   <= {NUM_IRQ{1'b0}};
      pending_r <= {NUM_IRQ{1'b0}};
      mask_r    <= {NUM_IRQ{1'b0}};
      irq_id_r  <= {ID_WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      irq_q_r   <= irq;
      pending_r <= pending_s;
      if (mask_we) begin
        mask_r <= mask_in;
      end else begin
        mask_r <= mask_r;
      end
      if (grant_s) begin
        irq_id_r <= win_id_s;
      end else begin
        irq_id_r <= irq_id_r;
      end
    end
  end

  // Moore outputs registered from the next state so they align with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inta_r       <= 1'b0;
      pc_restore_r <= 1'b0;
      in_service_r <= 1'b0;
    end else begin
      inta_r       <= (state_s == ACK);
      pc_restore_r <= (state_s == RETURN);
      in_service_r <= (state_s != IDLE);
    end
  end

  assign inta       = inta_r;
  assign pc_restore = pc_restore_r;
  assign in_service = in_service_r;
  assign irq_id     = irq_id_r;
  assign pending    = pending_r;
  assign mask       = mask_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: expected inta/pc_restore pulses are queued with
// their cycle and line id, and a negedge monitor pops and compares each observed pulse.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       int_enable;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       instr_boundary;
  logic       reti;
  logic       inta;
  logic       pc_restore;
  logic [1:0] irq_id;
  logic       in_service;
  logic [3:0] pending;
  logic [3:0] mask;

  always #5 clk = ~clk;

  interrupt_controller #(.NUM_IRQ(4), .ID_WIDTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .irq            (irq),
    .int_enable     (int_enable),
    .mask_we        (mask_we),
    .mask_in        (mask_in),
    .instr_boundary (instr_boundary),
    .reti           (reti),
    .inta           (inta),
    .pc_restore     (pc_restore),
    .irq_id         (irq_id),
    .in_service     (in_service),
    .pending        (pending),
    .mask           (mask)
  );

  typedef struct {
    logic       kind;   // 0 = inta, 1 = pc_restore
    logic [1:0] id;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input logic kind, input logic [1:0] id, input int at);
    ev_t e;
    e.kind = kind;
    e.id   = id;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we = 1'b1;
    mask_in = m;
    step(1);
    mask_we = 1'b0;
  endtask

  // Called while in SERVICE: reti for one edge, RETURN next cycle, IDLE the cycle after.
  task automatic service_return(input logic [1:0] id);
    reti = 1'b1;
    push_ev(1'b1, id, cyc + 1);
    step(1);
    reti = 1'b0;
    step(1);
    check("idle_after_return", {31'd0, in_service}, 32'd0);
  endtask

  task automatic observe(input logic kind);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: got pulse id=%0d at cycle %0d, required none",
               kind ? "pc_restore" : "inta", irq_id, cyc);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind !== kind) || (e.id !== irq_id) || (e.cyc != cyc)) begin
        bad++;
        $display("FAIL pulse: got %s id=%0d cycle=%0d, required %s id=%0d cycle=%0d",
                 kind ? "pc_restore" : "inta", irq_id, cyc,
                 e.kind ? "pc_restore" : "inta", e.id, e.cyc);
      end
    end
  endtask

  // Monitor: every pulse the DUT presents is matched against the queue head.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (inta === 1'b1) observe(1'b0);
      if (pc_restore === 1'b1) observe(1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    irq            = 4'b0000;
    int_enable     = 1'b0;
    mask_we        = 1'b0;
    mask_in        = 4'b0000;
    instr_boundary = 1'b0;
    reti           = 1'b0;
    step(2);
    check("rst_inta",       {31'd0, inta},       32'd0);
    check("rst_pc_restore", {31'd0, pc_restore}, 32'd0);
    check("rst_in_service", {31'd0, in_service}, 32'd0);
    check("rst_irq_id",     {30'd0, irq_id},     32'd0);
    check("rst_pending",    {28'd0, pending},    32'd0);
    check("rst_mask",       {28'd0, mask},       32'd0);
    reset = 1'b0;
    step(1);

    // Single grant on line 2.
    write_mask(4'b1111);
    check("mask_written", {28'd0, mask}, 32'h0000000f);
    int_enable     = 1'b1;
    instr_boundary = 1'b1;
    irq            = 4'b0100;
    push_ev(1'b0, 2'd2, cyc + 2);
    step(1);
    check("single_pending", {28'd0, pending}, 32'h4);
    check("single_no_inta_yet", {31'd0, inta}, 32'd0);
    step(1);
    check("single_inta", {31'd0, inta}, 32'd1);
    check("single_id", {30'd0, irq_id}, 32'd2);
    check("single_pending_clr", {28'd0, pending}, 32'd0);
    check("single_in_service", {31'd0, in_service}, 32'd1);
    step(1);
    check("single_inta_one_cycle", {31'd0, inta}, 32'd0);
    service_return(2'd2);
    check("ret_id_held", {30'd0, irq_id}, 32'd2);

    // Priority: lines 3 and 1 together (line 2 held high must not re-trigger).
    irq = 4'b1110;
    push_ev(1'b0, 2'd1, cyc + 2);
    step(2);
    check("prio_first_id", {30'd0, irq_id}, 32'd1);
    check("prio_pending", {28'd0, pending}, 32'h8);
    step(1);
    service_return(2'd1);
    push_ev(1'b0, 2'd3, cyc + 1);
    step(1);
    check("prio_second_id", {30'd0, irq_id}, 32'd3);
    step(1);
    service_return(2'd3);

    // Masked line stays pending until the mask enables it.
    irq = 4'b0000;
    step(1);
    write_mask(4'b0001);
    irq = 4'b0100;
    step(4);
    check("masked_pending", {28'd0, pending}, 32'h4);
    check("masked_idle", {31'd0, in_service}, 32'd0);
    push_ev(1'b0, 2'd2, cyc + 2);
    write_mask(4'b0100);
    step(1);
    check("unmasked_inta", {31'd0, inta}, 32'd1);
    step(1);
    service_return(2'd2);

    // Global enable gating.
    irq = 4'b0000;
    step(1);
    int_enable = 1'b0;
    irq        = 4'b0100;
    step(4);
    check("disabled_pending", {28'd0, pending}, 32'h4);
    check("disabled_idle", {31'd0, in_service}, 32'd0);
    int_enable = 1'b1;
    push_ev(1'b0, 2'd2, cyc + 1);
    step(1);
    check("enabled_inta", {31'd0, inta}, 32'd1);
    step(1);
    service_return(2'd2);

    // Instruction-boundary gating, then no nesting during SERVICE.
    irq = 4'b0000;
    step(1);
    write_mask(4'b1111);
    instr_boundary = 1'b0;
    irq            = 4'b0010;
    step(5);
    check("boundary_pending", {28'd0, pending}, 32'h2);
    check("boundary_idle", {31'd0, in_service}, 32'd0);
    instr_boundary = 1'b1;
    push_ev(1'b0, 2'd1, cyc + 1);
    step(1);
    check("boundary_inta", {31'd0, inta}, 32'd1);
    step(1);
    irq = 4'b0011;
    step(2);
    check("nest_pending", {28'd0, pending}, 32'h1);
    check("nest_in_service", {31'd0, in_service}, 32'd1);
    check("nest_id", {30'd0, irq_id}, 32'd1);
    service_return(2'd1);
    push_ev(1'b0, 2'd0, cyc + 1);
    step(1);
    check("after_return_id", {30'd0, irq_id}, 32'd0);
    step(1);
    service_return(2'd0);

    // Re-rise of line 0 on its own grant edge keeps it pending.
    irq = 4'b0000;
    step(1);
    instr_boundary = 1'b0;
    irq            = 4'b0001;
    step(1);
    irq = 4'b0000;
    step(1);
    irq            = 4'b0001;
    instr_boundary = 1'b1;
    push_ev(1'b0, 2'd0, cyc + 1);
    step(1);
    check("setclr_inta", {31'd0, inta}, 32'd1);
    check("setclr_pending", {28'd0, pending}, 32'h1);
    step(1);
    service_return(2'd0);
    push_ev(1'b0, 2'd0, cyc + 1);
    step(1);
    check("setclr_regrant_pending", {28'd0, pending}, 32'd0);
    step(1);
    service_return(2'd0);

    // Spurious reti in IDLE.
    reti = 1'b1;
    step(3);
    check("spurious_reti_restore", {31'd0, pc_restore}, 32'd0);
    check("spurious_reti_idle", {31'd0, in_service}, 32'd0);
    reti = 1'b0;

    // Asynchronous reset in SERVICE.
    irq = 4'b0000;
    step(1);
    irq = 4'b1000;
    push_ev(1'b0, 2'd3, cyc + 2);
    step(2);
    check("pre_reset_inta", {31'd0, inta}, 32'd1);
    irq = 4'b1100;
    step(1);
    #2;
    reset = 1'b1;
    #1;
    check("async_in_service", {31'd0, in_service}, 32'd0);
    check("async_pending", {28'd0, pending}, 32'd0);
    check("async_mask", {28'd0, mask}, 32'd0);
    check("async_irq_id", {30'd0, irq_id}, 32'd0);
    irq = 4'b0000;
    step(2);
    reset = 1'b0;
    irq   = 4'b0010;
    step(3);
    check("post_reset_pending", {28'd0, pending}, 32'h2);
    check("post_reset_no_grant", {31'd0, in_service}, 32'd0);
    write_mask(4'b0010);
    push_ev(1'b0, 2'd1, cyc + 1);
    step(1);
    check("post_reset_inta", {31'd0, inta}, 32'd1);
    step(1);
    service_return(2'd1);
    step(2);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Prioritised interrupt controller that sequences the program counter's interrupt-acknowledge path.
- Latches rising edges on external IRQ lines, applies a per-line mask and a global enable, and waits for an instruction boundary.
- Issues a one-cycle `inta` pulse to the program counter, which saves its backup address and jumps to 0.
- On return-from-interrupt, issues a one-cycle `pc_restore` pulse so the datapath reloads the backed-up PC. No nesting.

Parameters:
- NUM_IRQ, 4, number of interrupt request lines (1..16).
- ID_WIDTH, 2, width of `irq_id`; must satisfy 2^ID_WIDTH >= NUM_IRQ.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq  input  NUM_IRQ  external requests; a rising edge makes a line pending.
- int_enable  input  1  global interrupt enable from the control unit.
- mask_we  input  1  write strobe for the mask register.
- mask_in  input  NUM_IRQ  new mask value; bit=1 means the line is enabled.
- instr_boundary  input  1  high when the CPU may accept an interrupt this cycle.
- reti  input  1  return-from-interrupt instruction executing.
- inta  output  1  interrupt acknowledge to the program counter; one-cycle pulse.
- pc_restore  output  1  one-cycle pulse selecting the backup PC on return.
- irq_id  output  ID_WIDTH  index of the line currently being serviced.
- in_service  output  1  high from the `inta` cycle until `pc_restore` completes.
- pending  output  NUM_IRQ  pending register, for status readback.
- mask  output  NUM_IRQ  current mask register.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - `inta`, `pc_restore`, `in_service` = 0.
  - `irq_id` = 0, `pending` = 0, `mask` = 0 (all lines disabled).
  - Internal `irq_q` = 0.
- Edge detect, every posedge:
  - `irq_q` <= `irq`.
  - `rise` = `irq` & ~`irq_q`.
  - `pending[i]` sets at the edge where `rise[i]` = 1.
  - If a set and the grant-clear of the same bit coincide, set wins (the new edge is not lost).
- Mask:
  - `mask` <= `mask_in` at a posedge where `mask_we` = 1.
  - A grant in the same cycle uses the old mask.
- Request vector: `req` = `pending` & `mask`, qualified by `int_enable`.
- Priority: lowest index wins (bit 0 highest).
- FSM, registered Moore outputs, states IDLE, ACK, SERVICE, RETURN:
  - **IDLE:** if `req` != 0 and `instr_boundary` = 1 at a posedge:
    - `irq_id` <= winning index;
    - `pending[winning index]` cleared (unless a simultaneous rise);
    - go to ACK.
    - Otherwise stay. `reti` in IDLE is ignored.
  - **ACK:** `inta` = 1, `in_service` = 1. Lasts exactly one cycle, then SERVICE unconditionally. `reti` during ACK is ignored.
  - **SERVICE:** `in_service` = 1, `inta` = 0. No further grants (no nesting); new edges still accumulate in `pending`. `reti` = 1 at a posedge goes to RETURN.
  - **RETURN:** `pc_restore` = 1, `in_service` = 1 for exactly one cycle, then IDLE. `irq_id` holds its value until the next grant.
- Latency: the posedge that latches a rise is edge k. With `mask`/`int_enable`/`instr_boundary` high at edge k+1, the grant occurs and `inta` is high during the cycle following edge k+1. Minimum two posedges from irq rising to `inta`.
- Back-to-back: after RETURN, a still-pending request can be granted at the first IDLE posedge. Minimum spacing is four cycles from `inta` to the next `inta`.
- Masked or globally disabled lines remain pending and are granted once enabled.
- Level-held `irq` produces exactly one pending event per rising edge.
- Reset asserted during ACK/SERVICE/RETURN aborts immediately to reset values; no `pc_restore` is emitted.

Test Plan:
- **Single grant.** Reset, then `mask`=4'b1111, `int_enable`=1, `instr_boundary`=1; `irq[2]` rises.
  -> `pending`=4'b0100 after one edge; `inta` high for exactly 1 cycle on the second cycle after the rise; `irq_id`=2; `pending`=0.
- **Priority.** `irq[3]` and `irq[1]` rise together.
  -> first grant `irq_id`=1; `reti`, `pc_restore` pulse; second grant `irq_id`=3 four cycles after the first `inta`.
- **Masking and gating.**
  - `mask`=4'b0001, `irq[2]` rises. -> no `inta`, `pending[2]`=1. Write `mask`=4'b0100. -> `inta` with `irq_id`=2.
  - Repeat with `int_enable`=0. -> no `inta` until `int_enable`=1.
- **Boundary gating and no nesting.**
  - `instr_boundary`=0 for 5 cycles with a pending request. -> no `inta` until `instr_boundary`=1.
  - During SERVICE, `irq[0]` rises. -> no `inta`; `pending[0]`=1; granted right after RETURN.
- **Simultaneous set/clear and spurious `reti`.**
  - `irq[0]` re-rises on the grant edge of line 0. -> `pending[0]` remains 1.
  - `reti` in IDLE. -> no `pc_restore`.
- **Reset mid-service.** Assert `reset` asynchronously in SERVICE.
  -> `in_service`, `pending`, `mask`, `irq_id` = 0 immediately; no `pc_restore`; after release, `irq` rises are ignored until `mask` is written.
